// File: rtl/adc_fifo_pkg.sv
// adc_fifo_pkg: shared types and helpers for sync_sample_fifo
package adc_fifo_pkg;
  typedef logic [31:0] level_t;
  typedef struct packed {
    logic overflow;
    logic underflow;
  } sticky_t;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port sample store, one write port, one registered read port
// ports: clk, rst_n (sync, active-low, clears read register only), wr_en/wr_addr/wr_data, rd_en/rd_addr -> rd_data
module sync_fifo_mem import adc_fifo_pkg::*; #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] r_mem [2**ADDR_W];
  logic [WIDTH-1:0] r_rd_data;
  always_ff @(posedge clk)
    if (wr_en) r_mem[wr_addr] <= wr_data;
  always_ff @(posedge clk)
    if (!rst_n) r_rd_data <= '0;
    else if (rd_en) r_rd_data <= r_mem[rd_addr];
  assign rd_data = r_rd_data;
endmodule

// File: rtl/sync_sample_fifo.sv
// sync_sample_fifo: single-clock sample FIFO with standard or first-word-fall-through read
// ports: clk, rst_n (sync, active-low); write side wr_en/wr_data/wr_full/wr_almost_full;
// read side rd_en/rd_data/rd_valid/rd_empty/rd_almost_empty; level; clr_flags/overflow/underflow;
// peak_level only when SYNC_SAMPLE_FIFO_PEAK_EN is defined
module sync_sample_fifo import adc_fifo_pkg::*; #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 1024,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_full,
  output logic                   wr_almost_full,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   rd_empty,
  output logic                   rd_almost_empty,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   clr_flags,
  output logic                   overflow,
  output logic                   underflow
`ifdef SYNC_SAMPLE_FIFO_PEAK_EN
  ,
  output logic [$clog2(DEPTH):0] peak_level
`endif
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam int LW = ADDR_W + 1;
  logic [ADDR_W:0] r_wr_ptr, r_rd_ptr, w_count;
  logic r_rd_valid, w_wr_fire, w_rd_fire, w_mem_rd;
  sticky_t r_flags;
  always_comb begin
    w_count = r_wr_ptr - r_rd_ptr;
    wr_full = w_count == LW'(DEPTH);
    rd_empty = (FWFT != 0) ? !r_rd_valid : (w_count == '0);
    w_wr_fire = wr_en && !wr_full;
    w_rd_fire = rd_en && !rd_empty;
    // FWFT refills the output register whenever it is empty or being popped
    w_mem_rd = (FWFT != 0) ? (w_count != '0) && (!r_rd_valid || w_rd_fire) : w_rd_fire;
    level = w_count + ((FWFT != 0) ? LW'(r_rd_valid) : '0);
    wr_almost_full = level_t'(level) >= level_t'(AF_THRESH);
    rd_almost_empty = level_t'(level) <= level_t'(AE_THRESH);
  end
  sync_fifo_mem #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (w_wr_fire),
    .wr_addr(r_wr_ptr[ADDR_W-1:0]),
    .wr_data(wr_data),
    .rd_en  (w_mem_rd),
    .rd_addr(r_rd_ptr[ADDR_W-1:0]),
    .rd_data(rd_data)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rd_valid <= 1'b0;
      r_flags <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + LW'(1);
      if (w_mem_rd) r_rd_ptr <= r_rd_ptr + LW'(1);
      r_rd_valid <= (FWFT != 0) ? w_mem_rd || (r_rd_valid && !w_rd_fire) : w_rd_fire;
      r_flags.overflow <= (wr_en && wr_full) || (r_flags.overflow && !clr_flags);
      r_flags.underflow <= (rd_en && rd_empty) || (r_flags.underflow && !clr_flags);
    end
  end
  assign rd_valid = r_rd_valid;
  assign overflow = r_flags.overflow;
  assign underflow = r_flags.underflow;
`ifdef SYNC_SAMPLE_FIFO_PEAK_EN
  logic [ADDR_W:0] r_peak;
  always_ff @(posedge clk)
    if (!rst_n) r_peak <= '0;
    else r_peak <= (clr_flags || level > r_peak) ? level : r_peak;
  assign peak_level = r_peak;
`endif
endmodule

// File: tb/tb_sync_sample_fifo.sv
// tb_sync_sample_fifo: scoreboard bench for standard (u0) and FWFT (u1) 8-deep instances
module tb_sync_sample_fifo;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n = 0;
  logic wr_en0 = 0, rd_en0 = 0, clr0 = 0, wr_en1 = 0, rd_en1 = 0, clr1 = 0;
  logic [15:0] wr_data0 = 0, wr_data1 = 0, rd_data0, rd_data1;
  logic wr_full0, wr_af0, rd_valid0, rd_empty0, rd_ae0, ovf0, unf0;
  logic wr_full1, wr_af1, rd_valid1, rd_empty1, rd_ae1, ovf1, unf1;
  logic [3:0] level0, level1;
`ifdef SYNC_SAMPLE_FIFO_PEAK_EN
  logic [3:0] peak0, peak1;
`endif
  sync_sample_fifo #(.WIDTH(16), .DEPTH(8), .FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_data(wr_data0), .wr_full(wr_full0),
    .wr_almost_full(wr_af0), .rd_en(rd_en0), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .rd_empty(rd_empty0), .rd_almost_empty(rd_ae0), .level(level0), .clr_flags(clr0),
    .overflow(ovf0), .underflow(unf0)
`ifdef SYNC_SAMPLE_FIFO_PEAK_EN
    , .peak_level(peak0)
`endif
  );
  sync_sample_fifo #(.WIDTH(16), .DEPTH(8), .FWFT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_data(wr_data1), .wr_full(wr_full1),
    .wr_almost_full(wr_af1), .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .rd_empty(rd_empty1), .rd_almost_empty(rd_ae1), .level(level1), .clr_flags(clr1),
    .overflow(ovf1), .underflow(unf1)
`ifdef SYNC_SAMPLE_FIFO_PEAK_EN
    , .peak_level(peak1)
`endif
  );
  int checks = 0, failures = 0, mcount0 = 0, acc_w0 = 0, pops1 = 0, written = 0;
  logic [15:0] q0[$], q1[$];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && rd_valid0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL rd0_unexpected: got %h expected no output", rd_data0);
      end else begin
        logic [15:0] e;
        e = q0.pop_front();
        if (rd_data0 !== e) begin
          failures++;
          $display("FAIL rd0_data: got %h expected %h", rd_data0, e);
        end
      end
    end
  always @(negedge clk)
    if (rst_n && rd_valid1 && rd_en1) begin
      checks++;
      pops1++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL rd1_unexpected: got %h expected no output", rd_data1);
      end else begin
        logic [15:0] e;
        e = q1.pop_front();
        if (rd_data1 !== e) begin
          failures++;
          $display("FAIL rd1_data: got %h expected %h", rd_data1, e);
        end
      end
    end
  task automatic step0(input logic we, input logic [15:0] d, input logic re, input logic cl);
    int w, r;
    wr_en0 = we; wr_data0 = d; rd_en0 = re; clr0 = cl;
    w = (we && mcount0 < 8) ? 1 : 0;
    r = (re && mcount0 > 0) ? 1 : 0;
    if (w != 0) q0.push_back(d);
    mcount0 += w - r;
    acc_w0 = w;
    @(posedge clk); #1;
    wr_en0 = 0; rd_en0 = 0; clr0 = 0;
  endtask
  task automatic step1(input logic we, input logic [15:0] d, input logic re);
    wr_en1 = we; wr_data1 = d; rd_en1 = re;
    if (we) q1.push_back(d);
    @(posedge clk); #1;
    wr_en1 = 0; rd_en1 = 0;
  endtask
  task automatic chk_reset0();
    chk("rst_empty", rd_empty0, 1);
    chk("rst_full", wr_full0, 0);
    chk("rst_level", level0, 0);
    chk("rst_af", wr_af0, 0);
    chk("rst_ae", rd_ae0, 1);
    chk("rst_valid", rd_valid0, 0);
    chk("rst_data", rd_data0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_unf", unf0, 0);
`ifdef SYNC_SAMPLE_FIFO_PEAK_EN
    chk("rst_peak", peak0, 0);
`endif
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset0();
    chk("rst_valid1", rd_valid1, 0);
    chk("rst_empty1", rd_empty1, 1);
    rst_n = 1;
    for (int i = 1; i <= 8; i++) begin
      step0(1, 16'(i), 0, 0);
      if (i == 3) chk("af_below", wr_af0, 0);
      if (i == 4) begin
        chk("af_at", wr_af0, 1);
        chk("ae_at", rd_ae0, 1);
      end
      if (i == 5) chk("ae_above", rd_ae0, 0);
    end
    chk("full8", wr_full0, 1);
    chk("level8", level0, 8);
    chk("ovf_pre", ovf0, 0);
    step0(1, 16'h0009, 0, 0);
    chk("ovf_set", ovf0, 1);
    chk("level_ovf", level0, 8);
`ifdef SYNC_SAMPLE_FIFO_PEAK_EN
    chk("peak8", peak0, 8);
`endif
    step0(0, 0, 0, 1);
    chk("ovf_clr", ovf0, 0);
    for (int i = 0; i < 8; i++) step0(0, 0, 1, 0);
    step0(0, 0, 0, 0);
    chk("empty_drain", rd_empty0, 1);
    chk("level_drain", level0, 0);
    chk("unf_pre", unf0, 0);
    step0(0, 0, 1, 0);
    chk("unf_set", unf0, 1);
    chk("data_hold", rd_data0, 16'h0008);
    chk("valid_uf", rd_valid0, 0);
    step0(0, 0, 1, 1);
    chk("unf_set_wins", unf0, 1);
    step0(0, 0, 0, 1);
    chk("unf_clr", unf0, 0);
    for (int i = 0; i < 8; i++) step0(1, 16'h0010 + 16'(i), 0, 0);
    step0(1, 16'h0099, 1, 0);
    chk("full_rw_ovf", ovf0, 1);
    chk("full_rw_level", level0, 7);
    for (int i = 0; i < 7; i++) step0(0, 0, 1, 0);
    step0(0, 0, 0, 1);
    chk("level_empty2", level0, 0);
    step0(1, 16'h0055, 1, 0);
    chk("empty_rw_unf", unf0, 1);
    chk("empty_rw_level", level0, 1);
    chk("empty_rw_ovf", ovf0, 0);
    step0(0, 0, 1, 0);
    step0(0, 0, 0, 0);
    chk("level_empty3", level0, 0);
    step1(1, 16'hABCD, 0);
    chk("fwft_valid_k", rd_valid1, 0);
    chk("fwft_level_k", level1, 1);
    step1(0, 0, 0);
    chk("fwft_valid_k1", rd_valid1, 1);
    chk("fwft_data_k1", rd_data1, 16'hABCD);
    chk("fwft_empty_k1", rd_empty1, 0);
    for (int i = 1; i <= 6; i++) step1(1, 16'(i), 0);
    chk("fwft_level7", level1, 7);
    chk("fwft_head_hold", rd_data1, 16'hABCD);
    begin
      int p;
      p = pops1;
      for (int i = 0; i < 7; i++) step1(0, 0, 1);
      chk("fwft_no_gaps", pops1 - p, 7);
    end
    chk("fwft_valid_end", rd_valid1, 0);
    chk("fwft_empty_end", rd_empty1, 1);
    chk("fwft_level_end", level1, 0);
    for (int c = 0; c < 400 && written < 24; c++) begin
      step0(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, 16'h0100 + 16'(written),
            ($urandom_range(0, 1) != 0) ? 1'b1 : 1'b0, 0);
      written += acc_w0;
    end
    chk("stream_written", written, 24);
    for (int c = 0; c < 20 && mcount0 > 5; c++) step0(0, 0, 1, 0);
    for (int c = 0; c < 20 && mcount0 < 5; c++) step0(1, 16'h0200 + 16'(c), 0, 0);
    step0(0, 0, 0, 0);
    chk("stream_level5", level0, 5);
    chk("stream_af5", wr_af0, 1);
    rst_n = 0;
    step0(0, 0, 0, 0);
    chk_reset0();
    rst_n = 1;
    q0.delete();
    mcount0 = 0;
    step0(1, 16'h0AAA, 0, 0);
    chk("post_rst_level", level0, 1);
    step0(0, 0, 1, 0);
    step0(0, 0, 0, 0);
    chk("post_rst_empty", rd_empty0, 1);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
